// File: rtl/way_line_mux_pkg.sv
// Shared types and sizes for the L2 way-line selector.
// Optional byte-parity checking is enabled with `define WAY_LINE_MUX_PARITY_EN.
package way_line_mux_pkg;

    localparam int LINE_W = 512;
    localparam int WAYS   = 8;
    localparam int SEL_W  = 3;
    localparam int BYTES  = LINE_W / 8;

    typedef logic [LINE_W-1:0] line_t;
    typedef logic [SEL_W-1:0]  way_sel_t;
    typedef logic [BYTES-1:0]  par_t;

endpackage

// File: rtl/way_line_mux_if.sv
// Request/response bundle between the data-array read ports and the fill path.
// Parity lanes and parity_err exist only with `define WAY_LINE_MUX_PARITY_EN.
interface way_line_mux_if;
    import way_line_mux_pkg::*;

    way_sel_t select;
    line_t    in0;
    line_t    in1;
    line_t    in2;
    line_t    in3;
    line_t    in4;
    line_t    in5;
    line_t    in6;
    line_t    in7;
    logic     in_valid;
    logic     in_ready;

    line_t    out;
    logic     out_valid;
    logic     out_ready;
    way_sel_t out_sel;

`ifdef WAY_LINE_MUX_PARITY_EN
    par_t     par0;
    par_t     par1;
    par_t     par2;
    par_t     par3;
    par_t     par4;
    par_t     par5;
    par_t     par6;
    par_t     par7;
    logic     parity_err;

    modport master (
        output select, in0, in1, in2, in3, in4, in5, in6, in7, in_valid, out_ready,
        output par0, par1, par2, par3, par4, par5, par6, par7,
        input  in_ready, out, out_valid, out_sel, parity_err
    );

    modport slave (
        input  select, in0, in1, in2, in3, in4, in5, in6, in7, in_valid, out_ready,
        input  par0, par1, par2, par3, par4, par5, par6, par7,
        output in_ready, out, out_valid, out_sel, parity_err
    );
`else
    modport master (
        output select, in0, in1, in2, in3, in4, in5, in6, in7, in_valid, out_ready,
        input  in_ready, out, out_valid, out_sel
    );

    modport slave (
        input  select, in0, in1, in2, in3, in4, in5, in6, in7, in_valid, out_ready,
        output in_ready, out, out_valid, out_sel
    );
`endif

endinterface

// File: rtl/way_line_mux_sel.sv
// Combinational 8:1 line selector; with WAY_LINE_MUX_PARITY_EN it also flags
// a byte-parity mismatch on the selected way only.
module way_line_mux_sel
    import way_line_mux_pkg::*;
(
    input  way_sel_t sel,
    input  line_t    ways [WAYS],
    output line_t    line
`ifdef WAY_LINE_MUX_PARITY_EN
    ,
    input  par_t     pars [WAYS],
    output logic     par_err
`endif
);

    // All eight codes map to a real way, so no default arm is needed.
    always_comb begin
        line = ways[sel];
    end

`ifdef WAY_LINE_MUX_PARITY_EN
    // Even parity: XOR of the eight data bits equals the stored bit.
    function automatic logic byte_par_mismatch(line_t l, par_t p);
        logic e;
        e = 1'b0;
        for (int b = 0; b < BYTES; b++) begin
            e = e | ((^l[b*8 +: 8]) ^ p[b]);
        end
        return e;
    endfunction

    always_comb begin
        par_err = byte_par_mismatch(ways[sel], pars[sel]);
    end
`endif

endmodule

// File: rtl/way_line_mux.sv
// Registered 8:1 cache-line selector behind a valid/ready handshake.
// Define WAY_LINE_MUX_PARITY_EN to add per-byte parity checking of the chosen way.
module way_line_mux
    import way_line_mux_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    way_line_mux_if.slave  bus
);

    line_t    ways [WAYS];
    line_t    sel_line;
    logic     accept;

    line_t    line_p1;
    way_sel_t sel_p1;
    logic     vld_p1;

    assign ways[0] = bus.in0;
    assign ways[1] = bus.in1;
    assign ways[2] = bus.in2;
    assign ways[3] = bus.in3;
    assign ways[4] = bus.in4;
    assign ways[5] = bus.in5;
    assign ways[6] = bus.in6;
    assign ways[7] = bus.in7;

`ifdef WAY_LINE_MUX_PARITY_EN
    par_t pars [WAYS];
    logic sel_err;
    logic err_p1;

    assign pars[0] = bus.par0;
    assign pars[1] = bus.par1;
    assign pars[2] = bus.par2;
    assign pars[3] = bus.par3;
    assign pars[4] = bus.par4;
    assign pars[5] = bus.par5;
    assign pars[6] = bus.par6;
    assign pars[7] = bus.par7;

    way_line_mux_sel u_sel (
        .sel     (bus.select),
        .ways    (ways),
        .line    (sel_line),
        .pars    (pars),
        .par_err (sel_err)
    );
`else
    way_line_mux_sel u_sel (
        .sel  (bus.select),
        .ways (ways),
        .line (sel_line)
    );
`endif

    // The slot frees up in the same cycle it drains, giving one line per cycle.
    assign bus.in_ready = !vld_p1 || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    // ---- stage p1: output register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_p1 <= '0;
            sel_p1  <= '0;
            vld_p1  <= 1'b0;
        end else if (accept) begin
            line_p1 <= sel_line;
            sel_p1  <= bus.select;
            vld_p1  <= 1'b1;
        end else if (bus.out_ready) begin
            vld_p1  <= 1'b0;
        end
    end

`ifdef WAY_LINE_MUX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_p1 <= 1'b0;
        end else if (accept) begin
            err_p1 <= sel_err;
        end
    end

    assign bus.parity_err = err_p1;
`endif

    assign bus.out       = line_p1;
    assign bus.out_sel   = sel_p1;
    assign bus.out_valid = vld_p1;

endmodule

// File: tb/tb_way_line_mux.sv
// Scoreboard bench for way_line_mux: directed plan items plus randomized traffic.
// Build with +define+WAY_LINE_MUX_PARITY_EN to also exercise the parity path.
module tb_way_line_mux;
    import way_line_mux_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    way_line_mux_if bus ();

    way_line_mux dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        line_t    line;
        way_sel_t sel;
        logic     err;
    } exp_t;

    exp_t  q[$];
    line_t wayv [WAYS];
`ifdef WAY_LINE_MUX_PARITY_EN
    par_t  parv [WAYS];
`endif
    int checks = 0;
    int passes = 0;

    task automatic check(string name, line_t act, line_t exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else passes++;
    endtask

`ifdef WAY_LINE_MUX_PARITY_EN
    function automatic par_t good_par(line_t l);
        par_t p;
        for (int b = 0; b < BYTES; b++) p[b] = ($countones(l[b*8 +: 8]) % 2) == 1;
        return p;
    endfunction
`endif

    // Reference: line and select captured as-is; error if any byte plus its bit has odd weight.
    function automatic exp_t make_exp(way_sel_t s);
        exp_t e;
        e.line = wayv[s];
        e.sel  = s;
        e.err  = 1'b0;
`ifdef WAY_LINE_MUX_PARITY_EN
        for (int b = 0; b < BYTES; b++)
            if (($countones({wayv[s][b*8 +: 8], parv[s][b]}) % 2) != 0) e.err = 1'b1;
`endif
        return e;
    endfunction

    task automatic drive_ways();
        bus.in0 = wayv[0]; bus.in1 = wayv[1]; bus.in2 = wayv[2]; bus.in3 = wayv[3];
        bus.in4 = wayv[4]; bus.in5 = wayv[5]; bus.in6 = wayv[6]; bus.in7 = wayv[7];
`ifdef WAY_LINE_MUX_PARITY_EN
        bus.par0 = parv[0]; bus.par1 = parv[1]; bus.par2 = parv[2]; bus.par3 = parv[3];
        bus.par4 = parv[4]; bus.par5 = parv[5]; bus.par6 = parv[6]; bus.par7 = parv[7];
`endif
    endtask

    task automatic set_way(int k, line_t v);
        wayv[k] = v;
`ifdef WAY_LINE_MUX_PARITY_EN
        parv[k] = good_par(v);
`endif
        drive_ways();
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Model of the single output slot: a request is taken whenever the slot is empty
    // at the edge (the monitor empties it on the preceding falling edge if out_ready).
    always @(posedge clk) begin
        if (rst_n && bus.in_valid && q.size() == 0) q.push_back(make_exp(bus.select));
    end

    // Monitor
    always @(negedge clk) begin
        if (rst_n) begin
            check("out_valid", line_t'(bus.out_valid), line_t'(q.size() != 0));
            check("in_ready", line_t'(bus.in_ready), line_t'((q.size() == 0) || bus.out_ready));
            if (q.size() != 0) begin
                check("out", bus.out, q[0].line);
                check("out_sel", line_t'(bus.out_sel), line_t'(q[0].sel));
`ifdef WAY_LINE_MUX_PARITY_EN
                check("parity_err", line_t'(bus.parity_err), line_t'(q[0].err));
`endif
                if (bus.out_ready) void'(q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        line_t w;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.select    = '0;
        for (int k = 0; k < WAYS; k++) set_way(k, line_t'(1) << (4 * k));

        // Reset values straight out of reset
        #1;
        check("rst_out", bus.out, '0);
        check("rst_out_valid", line_t'(bus.out_valid), '0);
        check("rst_out_sel", line_t'(bus.out_sel), '0);
        check("rst_in_ready", line_t'(bus.in_ready), line_t'(1));
        @(negedge clk);
        #2 rst_n = 1'b1;
        cyc();

        // Select sweep, back to back
        for (int s = 0; s < WAYS; s++) begin
            bus.select = way_sel_t'(s); bus.in_valid = 1'b1; bus.out_ready = 1'b1;
            cyc();
        end
        bus.in_valid = 1'b0;
        cyc(); cyc();

        // Backpressure
        bus.select = 3'b010; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        cyc();
        bus.select = 3'b101; bus.out_ready = 1'b0;
        cyc(); cyc(); cyc();
        bus.out_ready = 1'b1;
        cyc();
        bus.in_valid = 1'b0;
        cyc(); cyc();

        // Input isolation
        bus.select = 3'b111; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        cyc();
        bus.in_valid = 1'b0;
        set_way(7, '1);
        cyc();
        bus.out_ready = 1'b1;
        cyc(); cyc();
        set_way(7, line_t'(1) << 28);

        // Full-width data
        set_way(4, {64{8'hAA}});
        bus.select = 3'b100; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        cyc();
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("bit511", line_t'(bus.out[511]), line_t'(1));
        cyc(); cyc();
        set_way(4, line_t'(1) << 16);

`ifdef WAY_LINE_MUX_PARITY_EN
        // Parity: corrupt byte 63 of the selected way, then of an unselected way
        parv[6][63] = ~parv[6][63];
        drive_ways();
        bus.select = 3'b110; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        cyc();
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("par_sel_err", line_t'(bus.parity_err), line_t'(1));
        cyc();
        parv[6] = good_par(wayv[6]);
        parv[1][63] = ~parv[1][63];
        drive_ways();
        bus.select = 3'b000; bus.in_valid = 1'b1;
        cyc();
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("par_unsel_ok", line_t'(bus.parity_err), line_t'(0));
        cyc();
        parv[1] = good_par(wayv[1]);
        drive_ways();
`endif

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                int k;
                k = int'($urandom_range(0, WAYS - 1));
                for (int j = 0; j < LINE_W / 32; j++) w[j*32 +: 32] = $urandom;
                set_way(k, w);
`ifdef WAY_LINE_MUX_PARITY_EN
                if ($urandom_range(0, 3) == 0) begin
                    parv[k][$urandom_range(0, BYTES - 1)] ^= 1'b1;
                    drive_ways();
                end
`endif
            end
            bus.select    = way_sel_t'($urandom_range(0, WAYS - 1));
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            cyc();
        end

        // Asynchronous reset while a line is held
        set_way(5, line_t'(1) << 20);
        bus.select = 3'b101; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        cyc();
        bus.in_valid = 1'b0;
        cyc();
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_out", bus.out, '0);
        check("mid_rst_out_valid", line_t'(bus.out_valid), '0);
        check("mid_rst_out_sel", line_t'(bus.out_sel), '0);
        check("mid_rst_in_ready", line_t'(bus.in_ready), line_t'(1));
        q.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;

        // First accept after reset behaves as from idle
        set_way(3, line_t'(1) << 12);
        bus.select = 3'b011; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        cyc();
        bus.in_valid = 1'b0;
        cyc(); cyc(); cyc();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
